// File: rtl/ff_share_arbiter.sv
// Round-robin arbiter that shares one D-type storage element between requesters A and B.
// Optional build macro FFARB_LOCK_EN adds pin p14 (LOCK), which holds off preemption.
module ff_share_arbiter #(
  parameter int unsigned MAX_HOLD = 8,
  parameter logic        Q_INIT   = 1'b0
) (
  input  logic p1,   // CLK
  input  logic p2,   // RST, synchronous, active-high
  input  logic p3,   // REQ_A
  input  logic p4,   // DATA_A
  input  logic p5,   // REQ_B
  input  logic p6,   // DATA_B
  input  logic p7,   // LOAD
  output logic p9,   // GNT_A
  output logic p10,  // GNT_B
  output logic p11,  // Q
  output logic p12,  // notQ
  output logic p13   // BUSY
`ifdef FFARB_LOCK_EN
  ,
  input  logic p14   // LOCK
`endif
);

  localparam int unsigned HW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : HW'(MAX_HOLD - 1);
  localparam logic [HW-1:0] HOLD_SAT  = '1;
  localparam bit PREEMPT_EN = (MAX_HOLD != 0);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } state_t;

  typedef enum logic {
    SIDE_A = 1'b0,
    SIDE_B = 1'b1
  } side_t;

  logic clk, rst, req_a, data_a, req_b, data_b, load, lock;

  assign clk    = p1;
  assign rst    = p2;
  assign req_a  = p3;
  assign data_a = p4;
  assign req_b  = p5;
  assign data_b = p6;
  assign load   = p7;
`ifdef FFARB_LOCK_EN
  assign lock   = p14;
`else
  assign lock   = 1'b0;
`endif

  state_t          state, state_nxt, other_state;
  side_t           last, last_nxt, own_side;
  logic [HW-1:0]   hold_cnt, hold_nxt;
  logic            own_req, other_req;
  logic            gnt_a, gnt_b, busy, q;

  always_comb begin
    // NOTE: every signal written here gets a default first; a path that skipped one would infer a latch.
    state_nxt   = state;
    last_nxt    = last;
    hold_nxt    = hold_cnt;
    own_side    = SIDE_A;
    own_req     = 1'b0;
    other_req   = 1'b0;
    other_state = IDLE;

    unique case (state)
      IDLE: begin
        // On a tie the side that was not served last wins.
        if (req_a && (!req_b || last == SIDE_B)) begin
          state_nxt = GRANT_A;
          hold_nxt  = '0;
        end else if (req_b) begin
          state_nxt = GRANT_B;
          hold_nxt  = '0;
        end
      end

      GRANT_A, GRANT_B: begin
        own_side    = (state == GRANT_A) ? SIDE_A : SIDE_B;
        own_req     = (state == GRANT_A) ? req_a  : req_b;
        other_req   = (state == GRANT_A) ? req_b  : req_a;
        other_state = (state == GRANT_A) ? GRANT_B : GRANT_A;

        if (!own_req) begin
          // Release hands over directly when the other side is waiting.
          last_nxt  = own_side;
          hold_nxt  = '0;
          state_nxt = other_req ? other_state : IDLE;
        end else if (other_req && !lock) begin
          if (PREEMPT_EN && hold_cnt == HOLD_LAST) begin
            last_nxt  = own_side;
            hold_nxt  = '0;
            state_nxt = other_state;
          end else if (hold_cnt != HOLD_SAT) begin
            hold_nxt = hold_cnt + 1'b1;
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state    <= IDLE;
      last     <= SIDE_B;
      hold_cnt <= '0;
      gnt_a    <= 1'b0;
      gnt_b    <= 1'b0;
      busy     <= 1'b0;
      q        <= Q_INIT;
    end else begin
      state    <= state_nxt;
      last     <= last_nxt;
      hold_cnt <= hold_nxt;
      gnt_a    <= (state_nxt == GRANT_A);
      gnt_b    <= (state_nxt == GRANT_B);
      busy     <= (state_nxt != IDLE);
      // LOAD follows the grant in force before this edge, even on a handover edge.
      if (load) begin
        if (state == GRANT_A)      q <= data_a;
        else if (state == GRANT_B) q <= data_b;
      end
    end
  end

  assign p9  = gnt_a;
  assign p10 = gnt_b;
  assign p11 = q;
  assign p12 = ~q;
  assign p13 = busy;

  a_one_grant: assert property (@(posedge clk) disable iff (rst) !(gnt_a && gnt_b));
  a_busy_or:   assert property (@(posedge clk) disable iff (rst) busy == (gnt_a | gnt_b));
  a_gnt_state: assert property (@(posedge clk) disable iff (rst)
                                (gnt_a == (state == GRANT_A)) && (gnt_b == (state == GRANT_B)));

endmodule

// File: tb/tb_ff_share_arbiter.sv
// Directed bench for ff_share_arbiter: a cycle-level reference model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_ff_share_arbiter;

  localparam int unsigned MAX_HOLD = 8;
  localparam logic        Q_INIT   = 1'b1;

  logic clk = 1'b0;
  logic rst, req_a, data_a, req_b, data_b, load, lock;
  logic gnt_a, gnt_b, q, nq, busy;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Reference model: who owns the element, who was served last, how long the other side has waited.
  int owner;      // -1 none, 0 A, 1 B
  int last_side;  // 0 A, 1 B
  int waited;
  bit mq;

  ff_share_arbiter #(.MAX_HOLD(MAX_HOLD), .Q_INIT(Q_INIT)) dut (
    .p1(clk), .p2(rst), .p3(req_a), .p4(data_a), .p5(req_b), .p6(data_b), .p7(load),
    .p9(gnt_a), .p10(gnt_b), .p11(q), .p12(nq), .p13(busy)
`ifdef FFARB_LOCK_EN
    , .p14(lock)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %b, want %b", name, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    bit r[2];
    bit d[2];
    bit lk;
    int o;
    r[0] = req_a;  r[1] = req_b;
    d[0] = data_a; d[1] = data_b;
`ifdef FFARB_LOCK_EN
    lk = lock;
`else
    lk = 1'b0;
`endif
    if (rst) begin
      owner = -1; last_side = 1; waited = 0; mq = Q_INIT;
    end else begin
      if (load && owner >= 0) mq = d[owner];
      if (owner < 0) begin
        if (r[0] && r[1]) owner = 1 - last_side;
        else if (r[0])    owner = 0;
        else if (r[1])    owner = 1;
        waited = 0;
      end else begin
        o = owner;
        if (!r[o]) begin
          last_side = o;
          owner = r[1-o] ? 1 - o : -1;
          waited = 0;
        end else if (r[1-o] && !lk) begin
          if (MAX_HOLD != 0 && waited + 1 >= MAX_HOLD) begin
            last_side = o; owner = 1 - o; waited = 0;
          end else begin
            waited++;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("gnt_a", gnt_a, owner == 0);
      check("gnt_b", gnt_b, owner == 1);
      check("q",     q,     mq);
      check("notq",  nq,    !mq);
      check("busy",  busy,  owner >= 0);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; req_a = 1'b0; data_a = 1'b0; req_b = 1'b0; data_b = 1'b0;
    load = 1'b0; lock = 1'b0;

    // Reset state
    step(1);
    chk_en = 1'b1;
    step(1);
    rst = 1'b0;
    check("rst_gnt_a", gnt_a, 1'b0);
    check("rst_gnt_b", gnt_b, 1'b0);
    check("rst_busy",  busy,  1'b0);
    check("rst_q",     q,     1'b1);
    check("rst_notq",  nq,    1'b0);

    // LOAD in IDLE is ignored
    load = 1'b1; data_a = 1'b0; data_b = 1'b0;
    step(1);
    check("idle_load_q", q, 1'b1);
    load = 1'b0;

    // Single request, then load A's data
    req_a = 1'b1;
    step(1);
    check("a_grant", gnt_a, 1'b1);
    load = 1'b1; data_a = 1'b0; data_b = 1'b1;
    step(1);
    check("a_load_q", q, 1'b0);
    load = 1'b0;
    req_a = 1'b0;
    step(1);
    check("a_release", busy, 1'b0);

    // B alone, so B becomes last
    req_b = 1'b1;
    step(1);
    check("b_grant", gnt_b, 1'b1);
    req_b = 1'b0;
    step(1);

    // Tie with B last: A first, then B with no gap, then A again on a fresh tie
    req_a = 1'b1; req_b = 1'b1;
    step(1);
    check("tie1_a", gnt_a, 1'b1);
    req_a = 1'b0;
    step(1);
    check("handover_b", gnt_b, 1'b1);
    check("handover_busy", busy, 1'b1);
    req_b = 1'b0;
    step(1);
    check("tie_idle", busy, 1'b0);
    req_a = 1'b1; req_b = 1'b1;
    step(1);
    check("tie2_a", gnt_a, 1'b1);

    // A never drops while B waits: preempted on the 8th waiting edge; LOAD hits A on that edge
    step(MAX_HOLD - 1);
    check("hold_a_last", gnt_a, 1'b1);
    load = 1'b1; data_a = 1'b1; data_b = 1'b0;
    step(1);
    check("preempt_b", gnt_b, 1'b1);
    check("preempt_gnt_a", gnt_a, 1'b0);
    check("preempt_load_q", q, 1'b1);
    load = 1'b0;
    req_b = 1'b0;
    step(1);
    check("regrant_a", gnt_a, 1'b1);
    req_a = 1'b0;
    step(1);

`ifdef FFARB_LOCK_EN
    // LOCK from the start of the grant: no preemption until released, then 8 further waits
    lock = 1'b1; req_a = 1'b1; req_b = 1'b1;
    step(1);
    check("lock_b", gnt_b, 1'b1);
    step(22);
    check("lock_hold_b", gnt_b, 1'b1);
    lock = 1'b0;
    step(MAX_HOLD - 1);
    check("unlock_hold_b", gnt_b, 1'b1);
    step(1);
    check("unlock_preempt_a", gnt_a, 1'b1);
    req_a = 1'b0; req_b = 1'b0;
    step(2);
`endif

    // Reset in the middle of a B grant, with LOAD active
    req_b = 1'b1;
    step(1);
    check("b_grant2", gnt_b, 1'b1);
    load = 1'b1; data_b = 1'b0;
    step(1);
    check("b_load_q", q, 1'b0);
    rst = 1'b1;
    step(1);
    check("midrst_gnt_b", gnt_b, 1'b0);
    check("midrst_busy",  busy,  1'b0);
    check("midrst_q",     q,     1'b1);
    rst = 1'b0; load = 1'b0; data_b = 1'b1;
    req_a = 1'b1; req_b = 1'b1;
    step(1);
    check("post_rst_tie_a", gnt_a, 1'b1);
    req_a = 1'b0; req_b = 1'b0;
    step(2);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
